// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared defaults and read-source encoding for regfile_sb
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  // Where a read port takes its data from, in priority order.
  typedef enum logic [1:0] {
    RD_SRC_ZERO = 2'd0,
    RD_SRC_WP1  = 2'd1,
    RD_SRC_WP0  = 2'd2,
    RD_SRC_REG  = 2'd3
  } rd_src_e;

  function automatic logic rd_src_is_bypass(input rd_src_e src);
    return (src == RD_SRC_WP1) || (src == RD_SRC_WP0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard, one bit per register
// Issue sets a bit, writeback clears it, and issue wins when both hit the same register.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen0,
  input  logic [ADDR_W-1:0]    waddr0,
  input  logic                 wen1,
  input  logic [ADDR_W-1:0]    waddr1,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (wen0) pending_d[waddr0] = 1'b0;
    if (wen1) pending_d[waddr1] = 1'b0;
    if (issue_en) pending_d[issue_addr] = 1'b1;
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending scoreboard
// Two write ports (port 1 is younger and wins), NRD combinational read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen0,
  input  logic [ADDR_W-1:0]      waddr0,
  input  logic [DATA_W-1:0]      wdata0,
  input  logic                   wen1,
  input  logic [ADDR_W-1:0]      waddr1,
  input  logic [DATA_W-1:0]      wdata1,
  input  logic [NRD*ADDR_W-1:0]  raddr,
  output logic [NRD*DATA_W-1:0]  rdata,
  output logic [NRD-1:0]         rbusy,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic [2**ADDR_W-1:0]   pending
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr0_ok;
  logic              wr1_ok;

  assign wr0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Port 1 is assigned last so it owns the entry when both ports collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr0_ok) regs_q[waddr0] <= wdata0;
      if (wr1_ok) regs_q[waddr1] <= wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .pending    (pending)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    rd_src_e           src;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      src = RD_SRC_REG;
      if ((ZERO_REG != 0) && (ra == '0)) begin
        src = RD_SRC_ZERO;
      end else if (wen1 && (ra == waddr1)) begin
        src = RD_SRC_WP1;
      end else if (wen0 && (ra == waddr0)) begin
        src = RD_SRC_WP0;
      end
    end

    always_comb begin
      rd = '0;
      case (src)
        RD_SRC_ZERO: rd = '0;
        RD_SRC_WP1:  rd = wdata1;
        RD_SRC_WP0:  rd = wdata0;
        RD_SRC_REG:  rd = regs_q[ra];
        default:     rd = '0;
      endcase
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
    // pending[0] is held at 0 when ZERO_REG is set, so r0 never reads busy.
    assign rbusy[i] = pending[ra] & ~rd_src_is_bypass(src);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized bench for regfile_sb, default and NRD=4/ADDR_W=4/DATA_W=16 builds
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0, wen1, issue_en;
  logic [4:0]  waddr0, waddr1, issue_addr;
  logic [31:0] wdata0, wdata1;
  logic [4:0]  ra [4];

  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic [31:0] pending_a;

  logic [15:0] raddr_b;
  logic [63:0] rdata_b;
  logic [3:0]  rbusy_b;
  logic [15:0] pending_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];

  always #5 clk = ~clk;

  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .issue_en(issue_en), .issue_addr(issue_addr), .pending(pending_a)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NRD(4), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0[3:0]), .wdata0(wdata0[15:0]),
    .wen1(wen1), .waddr1(waddr1[3:0]), .wdata1(wdata1[15:0]),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_en(issue_en), .issue_addr(issue_addr[3:0]), .pending(pending_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int amask(input int k);
    return (k == 0) ? 31 : 15;
  endfunction

  function automatic logic [31:0] dmask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference read: r0 reads zero, then younger write, older write, stored value.
  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a_in);
    int a = int'(a_in) & amask(k);
    if (a == 0) return 32'h0;
    if (wen1 && ((int'(waddr1) & amask(k)) == a)) return wdata1 & dmask(k);
    if (wen0 && ((int'(waddr0) & amask(k)) == a)) return wdata0 & dmask(k);
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] a_in);
    int a = int'(a_in) & amask(k);
    bit hit = (wen1 && ((int'(waddr1) & amask(k)) == a)) ||
              (wen0 && ((int'(waddr0) & amask(k)) == a));
    return (a != 0) && m_pend[k][a] && !hit;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int a0 = int'(waddr0) & amask(k);
      int a1 = int'(waddr1) & amask(k);
      int ia = int'(issue_addr) & amask(k);
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[k][r] = 32'h0;
          m_pend[k][r] = 1'b0;
        end
      end else begin
        if (wen0 && a0 != 0) m_regs[k][a0] = wdata0 & dmask(k);
        if (wen1 && a1 != 0) m_regs[k][a1] = wdata1 & dmask(k);
        if (wen0) m_pend[k][a0] = 1'b0;
        if (wen1) m_pend[k][a1] = 1'b0;
        if (issue_en) m_pend[k][ia] = 1'b1;
        m_pend[k][0] = 1'b0;
      end
    end
  endtask

  task automatic settle(input bit check_en);
    logic [31:0] pv_a;
    logic [15:0] pv_b;
    #1;
    if (check_en) begin
      for (int r = 0; r < 32; r++) pv_a[r] = m_pend[0][r];
      for (int r = 0; r < 16; r++) pv_b[r] = m_pend[1][r];
      chk("a_pending", pending_a, pv_a);
      chk("b_pending", pending_b, pv_b);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("a_rdata%0d", i), rdata_a[i*32 +: 32], exp_rd(0, ra[i]));
        chk($sformatf("a_rbusy%0d", i), rbusy_a[i], exp_busy(0, ra[i]));
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b_rdata%0d", i), rdata_b[i*16 +: 16], exp_rd(1, ra[i]));
        chk($sformatf("b_rbusy%0d", i), rbusy_b[i], exp_busy(1, ra[i]));
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; issue_en = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_addr = '0;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    set_idle();
    for (int i = 0; i < 4; i++) ra[i] = 5'(i);

    rst = 1'b1;
    settle(1'b0);
    edge_step();
    rst = 1'b1; wen0 = 1'b1; wen1 = 1'b1; issue_en = 1'b1;
    waddr0 = 5'd3; waddr1 = 5'd4; wdata0 = 32'h5555; wdata1 = 32'h6666; issue_addr = 5'd3;
    settle(1'b0);
    edge_step();

    set_idle();
    ra[0] = 5'd3; ra[1] = 5'd4;
    settle(1'b1);
    chk("rst_rdata0", rdata_a[31:0], 64'h0);
    chk("rst_rdata1", rdata_a[63:32], 64'h0);
    chk("rst_pending", pending_a, 64'h0);
    edge_step();

    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1111;
    wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h2222;
    ra[0] = 5'd5;
    settle(1'b1);
    chk("byp_same", rdata_a[31:0], 64'h2222);
    edge_step();
    set_idle();
    settle(1'b1);
    chk("byp_next", rdata_a[31:0], 64'h2222);
    edge_step();

    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD_BEEF;
    edge_step();
    set_idle();
    ra[0] = 5'd0; issue_en = 1'b1; issue_addr = 5'd0;
    settle(1'b1);
    chk("zero_rdata", rdata_a[31:0], 64'h0);
    edge_step();
    set_idle();
    settle(1'b1);
    chk("zero_pending", pending_a[0], 64'h0);
    edge_step();

    issue_en = 1'b1; issue_addr = 5'd7;
    edge_step();
    set_idle();
    ra[0] = 5'd7;
    settle(1'b1);
    chk("r7_busy", rbusy_a[0], 64'h1);
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h42;
    settle(1'b1);
    chk("r7_wb_busy", rbusy_a[0], 64'h0);
    chk("r7_wb_rdata", rdata_a[31:0], 64'h42);
    edge_step();
    set_idle();
    settle(1'b1);
    chk("r7_cleared", pending_a[7], 64'h0);
    edge_step();

    issue_en = 1'b1; issue_addr = 5'd9;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hABCD;
    edge_step();
    set_idle();
    ra[0] = 5'd9;
    settle(1'b1);
    chk("r9_pending", pending_a[9], 64'h1);
    chk("r9_rdata", rdata_a[31:0], 64'hABCD);
    chk("r9_busy", rbusy_a[0], 64'h1);
    edge_step();

    wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h1A1A;
    wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h2B2B;
    edge_step();
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3C3C;
    wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4D4D;
    edge_step();
    set_idle();
    for (int i = 0; i < 4; i++) ra[i] = 5'(i + 1);
    settle(1'b1);
    chk("p4_rd0", rdata_b[15:0],  64'h1A1A);
    chk("p4_rd1", rdata_b[31:16], 64'h2B2B);
    chk("p4_rd2", rdata_b[47:32], 64'h3C3C);
    chk("p4_rd3", rdata_b[63:48], 64'h4D4D);
    edge_step();

    for (int n = 0; n < 2000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      wen0       = 1'($urandom_range(0, 1));
      wen1       = 1'($urandom_range(0, 1));
      issue_en   = ($urandom_range(0, 2) == 0);
      waddr0     = pick_addr();
      waddr1     = pick_addr();
      issue_addr = pick_addr();
      wdata0     = $urandom;
      wdata1     = $urandom;
      for (int i = 0; i < 4; i++) ra[i] = pick_addr();
      settle(1'b1);
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
